// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the ALU operand-forwarding path: mux select encodings
// and the forwarding-source qualifier used by the hazard unit and the ALU.
package fwd_hazard_unit_pkg;

    localparam int ALU_MUX_SEL_W      = 2;
    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [ALU_MUX_SEL_W-1:0] {
        ALUMuxDataFromReg     = 2'b00,
        ALUMuxDataFromALU_MEM = 2'b01,
        ALUMuxDataFromMEM_WB  = 2'b10
    } alu_mux_sel_e;

    // x0 is hardwired to zero, so a write to it never produces forwardable data.
    function automatic logic is_fwd_source(input logic valid,
                                           input logic reg_write,
                                           input logic rd_nonzero);
        return valid & reg_write & rd_nonzero;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// Per-operand forwarding comparator: picks the youngest valid producer of rs
// among the ALU_MEM and MEM_WB stages, falling back to the register file.
module fwd_select
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rs_used,
    input  logic                  am_valid,
    input  logic                  am_reg_write,
    input  logic [REG_ADDR_W-1:0] am_rd,
    input  logic                  mw_valid,
    input  logic                  mw_reg_write,
    input  logic [REG_ADDR_W-1:0] mw_rd,
    output logic [ALU_MUX_SEL_W-1:0] sel
);

    logic am_src;
    logic mw_src;

    assign am_src = is_fwd_source(am_valid, am_reg_write, |am_rd);
    assign mw_src = is_fwd_source(mw_valid, mw_reg_write, |mw_rd);

    always_comb begin
        sel = ALUMuxDataFromReg;
        if (alu_valid && rs_used && (rs != '0)) begin
            if (am_src && (am_rd == rs)) begin
                sel = ALUMuxDataFromALU_MEM;
            end else if (mw_src && (mw_rd == rs)) begin
                sel = ALUMuxDataFromMEM_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller: shadows the destination registers
// of the ALU, ALU_MEM and MEM_WB stages and drives operand selects and stall.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  decValid,
    input  logic [REG_ADDR_W-1:0] decRs1,
    input  logic [REG_ADDR_W-1:0] decRs2,
    input  logic                  decRs1Used,
    input  logic                  decRs2Used,
    input  logic [REG_ADDR_W-1:0] decRd,
    input  logic                  decRegWrite,
    input  logic                  decIsLoad,
    input  logic                  flush,
    output logic [1:0]            select1,
    output logic [1:0]            select2,
    output logic                  stall,
    output logic [CNT_W-1:0]      stallCount
);

    logic                  alu_valid_reg;
    logic                  alu_valid_next;
    logic [REG_ADDR_W-1:0] alu_rd_reg;
    logic                  alu_reg_write_reg;
    logic                  alu_is_load_reg;
    logic [REG_ADDR_W-1:0] alu_rs1_reg;
    logic [REG_ADDR_W-1:0] alu_rs2_reg;
    logic                  alu_rs1_used_reg;
    logic                  alu_rs2_used_reg;

    logic                  am_valid_reg;
    logic [REG_ADDR_W-1:0] am_rd_reg;
    logic                  am_reg_write_reg;

    logic                  mw_valid_reg;
    logic [REG_ADDR_W-1:0] mw_rd_reg;
    logic                  mw_reg_write_reg;

    logic [CNT_W-1:0]      stall_count_reg;
    logic [CNT_W-1:0]      stall_count_next;
    logic                  stall_int;
    logic                  load_in_alu;

    // Flush wins over a plain issue; a stall turns the insert into a bubble.
    assign alu_valid_next = decValid & ~stall_int & ~flush;

    // Bubble entries still capture the decode fields; only valid is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid_reg     <= 1'b0;
            alu_rd_reg        <= '0;
            alu_reg_write_reg <= 1'b0;
            alu_is_load_reg   <= 1'b0;
            alu_rs1_reg       <= '0;
            alu_rs2_reg       <= '0;
            alu_rs1_used_reg  <= 1'b0;
            alu_rs2_used_reg  <= 1'b0;
            am_valid_reg      <= 1'b0;
            am_rd_reg         <= '0;
            am_reg_write_reg  <= 1'b0;
            mw_valid_reg      <= 1'b0;
            mw_rd_reg         <= '0;
            mw_reg_write_reg  <= 1'b0;
        end else begin
            mw_valid_reg      <= am_valid_reg;
            mw_rd_reg         <= am_rd_reg;
            mw_reg_write_reg  <= am_reg_write_reg;
            am_valid_reg      <= alu_valid_reg;
            am_rd_reg         <= alu_rd_reg;
            am_reg_write_reg  <= alu_reg_write_reg;
            alu_valid_reg     <= alu_valid_next;
            alu_rd_reg        <= decRd;
            alu_reg_write_reg <= decRegWrite;
            alu_is_load_reg   <= decIsLoad;
            alu_rs1_reg       <= decRs1;
            alu_rs2_reg       <= decRs2;
            alu_rs1_used_reg  <= decRs1Used;
            alu_rs2_used_reg  <= decRs2Used;
        end
    end

    // Only a load sitting in the ALU stage can stall; by ALU_MEM it forwards.
    assign load_in_alu = alu_valid_reg & alu_is_load_reg & alu_reg_write_reg & (|alu_rd_reg);
    assign stall_int   = decValid & load_in_alu &
                         ((decRs1Used & (decRs1 == alu_rd_reg)) |
                          (decRs2Used & (decRs2 == alu_rd_reg)));
    assign stall       = stall_int;

    always_comb begin
        stall_count_next = stall_count_reg;
        if (stall_int && (stall_count_reg != '1)) begin
            stall_count_next = stall_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
        end
    end

    assign stallCount = stall_count_reg;

    logic [REG_ADDR_W-1:0]    rs_arr   [2];
    logic                     used_arr [2];
    logic [ALU_MUX_SEL_W-1:0] sel_arr  [2];

    assign rs_arr[0]   = alu_rs1_reg;
    assign rs_arr[1]   = alu_rs2_reg;
    assign used_arr[0] = alu_rs1_used_reg;
    assign used_arr[1] = alu_rs2_used_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sel
            fwd_select #(
                .REG_ADDR_W (REG_ADDR_W)
            ) u_fwd_select (
                .alu_valid    (alu_valid_reg),
                .rs           (rs_arr[gi]),
                .rs_used      (used_arr[gi]),
                .am_valid     (am_valid_reg),
                .am_reg_write (am_reg_write_reg),
                .am_rd        (am_rd_reg),
                .mw_valid     (mw_valid_reg),
                .mw_reg_write (mw_reg_write_reg),
                .mw_rd        (mw_rd_reg),
                .sel          (sel_arr[gi])
            );
        end
    endgenerate

    assign select1 = sel_arr[0];
    assign select2 = sel_arr[1];

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: stimulus pushes hand-computed expectations
// into a scoreboard queue, a monitor pops and compares them away from the clock edge.
module tb_fwd_hazard_unit;

    localparam int RW = 5;
    localparam int CW = 4;
    localparam int K_SEL1 = 0;
    localparam int K_SEL2 = 1;
    localparam int K_STALL = 2;
    localparam int K_CNT = 3;

    typedef struct {
        string name;
        int    kind;
        int    val;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          decValid;
    logic [RW-1:0] decRs1;
    logic [RW-1:0] decRs2;
    logic          decRs1Used;
    logic          decRs2Used;
    logic [RW-1:0] decRd;
    logic          decRegWrite;
    logic          decIsLoad;
    logic          flush;
    logic [1:0]    select1;
    logic [1:0]    select2;
    logic          stall;
    logic [CW-1:0] stallCount;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;
    bit   done     = 0;

    fwd_hazard_unit #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .decValid    (decValid),
        .decRs1      (decRs1),
        .decRs2      (decRs2),
        .decRs1Used  (decRs1Used),
        .decRs2Used  (decRs2Used),
        .decRd       (decRd),
        .decRegWrite (decRegWrite),
        .decIsLoad   (decIsLoad),
        .flush       (flush),
        .select1     (select1),
        .select2     (select2),
        .stall       (stall),
        .stallCount  (stallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: outputs are stable mid-cycle, or right after an async reset.
    initial begin
        exp_t e;
        int   act;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.kind)
                    K_SEL1:  act = int'(select1);
                    K_SEL2:  act = int'(select2);
                    K_STALL: act = int'(stall);
                    default: act = int'(stallCount);
                endcase
                checks++;
                if (act != e.val) begin
                    failures++;
                    $display("FAIL %s kind=%0d actual=%0d expected=%0d t=%0t",
                             e.name, e.kind, act, e.val, $time);
                end else begin
                    $display("ok   %s kind=%0d value=%0d", e.name, e.kind, act);
                end
            end
        end
    end

    task automatic push(input string n, input int kind, input int val);
        exp_t e;
        e.name = n;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic exp3(input string n, input int s1, input int s2, input int st);
        push({n, "_sel1"}, K_SEL1, s1);
        push({n, "_sel2"}, K_SEL2, s2);
        push({n, "_stall"}, K_STALL, st);
    endtask

    task automatic dec(input logic v, input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2,
                       input logic [RW-1:0] rd, input logic rw, input logic ld);
        decValid    = v;
        decRs1      = rs1;
        decRs1Used  = u1;
        decRs2      = rs2;
        decRs2Used  = u2;
        decRd       = rd;
        decRegWrite = rw;
        decIsLoad   = ld;
        flush       = 1'b0;
    endtask

    task automatic nop();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) begin
            nop();
            tick();
        end
    endtask

    // Helpers for common instruction shapes.
    task automatic alu_op(input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        dec(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic load_op(input logic [RW-1:0] rd, input logic [RW-1:0] base);
        dec(1'b1, base, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1);
    endtask

    task automatic stall_seen();
        exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        exp3("reset", 0, 0, 0);
        push("reset_cnt", K_CNT, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Back-to-back ALU producer forwards from ALU_MEM.
        alu_op(5'd5, 5'd1, 5'd2); exp3("t1_add_dec", 0, 0, 0); tick();
        alu_op(5'd6, 5'd5, 5'd7); exp3("t1_sub_dec", 0, 0, 0); tick();
        nop(); exp3("t1_fwd_am", 1, 0, 0); tick();
        nop(); exp3("t1_bubble", 0, 0, 0); tick();
        drain();

        // Both stages produce x5: ALU_MEM wins.
        alu_op(5'd5, 5'd1, 5'd2); tick();
        alu_op(5'd5, 5'd3, 5'd4); tick();
        alu_op(5'd8, 5'd5, 5'd5); tick();
        nop(); exp3("t2_prio", 1, 1, 0); tick();
        drain();

        // One gap forwards from MEM_WB, two gaps read the register file.
        alu_op(5'd5, 5'd1, 5'd2); tick();
        nop(); tick();
        alu_op(5'd6, 5'd5, 5'd7); tick();
        nop(); exp3("t2_mw", 2, 0, 0); tick();
        drain();
        alu_op(5'd5, 5'd1, 5'd2); tick();
        nop(); tick();
        nop(); tick();
        alu_op(5'd6, 5'd5, 5'd7); tick();
        nop(); exp3("t2_gap2", 0, 0, 0); tick();
        drain();

        // Load-use on rs1: one stall, then MEM_WB forwarding.
        load_op(5'd3, 5'd2); push("t3_lw_stall", K_STALL, 0); tick();
        alu_op(5'd4, 5'd3, 5'd1); exp3("t3_stall", 0, 0, 1); push("t3_cnt0", K_CNT, 0);
        stall_seen(); tick();
        alu_op(5'd4, 5'd3, 5'd1); exp3("t3_hold", 0, 0, 0); push("t3_cnt1", K_CNT, 1); tick();
        nop(); exp3("t3_issue", 2, 0, 0); tick();
        drain();

        // Chain of dependent loads, last link via rs2: each stalls once.
        load_op(5'd3, 5'd2); tick();
        load_op(5'd4, 5'd3); push("t3b_chain1", K_STALL, 1); stall_seen(); tick();
        load_op(5'd4, 5'd3); push("t3b_chain1_hold", K_STALL, 0); tick();
        alu_op(5'd5, 5'd1, 5'd4); exp3("t3b_chain2", 2, 0, 1); stall_seen(); tick();
        alu_op(5'd5, 5'd1, 5'd4); exp3("t3b_chain2_hold", 0, 0, 0); tick();
        nop(); exp3("t3b_issue", 0, 2, 0); push("t3b_cnt", K_CNT, 3); tick();
        drain();

        // x0 is never forwarded and never causes a stall.
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); tick();
        alu_op(5'd6, 5'd0, 5'd0); tick();
        nop(); exp3("t4_x0", 0, 0, 0); tick();
        drain();
        load_op(5'd0, 5'd2); tick();
        alu_op(5'd6, 5'd0, 5'd0); push("t4_ld_x0", K_STALL, 0); tick();
        drain();

        // lui whose rs1 field matches but is not read.
        alu_op(5'd5, 5'd1, 5'd2); tick();
        dec(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd9, 1'b1, 1'b0); tick();
        nop(); exp3("t4_lui", 0, 0, 0); tick();
        drain();

        // Flush with a pending load-use stall.
        load_op(5'd3, 5'd2); tick();
        alu_op(5'd4, 5'd3, 5'd1); flush = 1'b1;
        exp3("t5_flush_stall", 0, 0, 1); stall_seen(); tick();
        alu_op(5'd4, 5'd3, 5'd1); exp3("t5_after", 0, 0, 0); tick();
        nop(); exp3("t5_issue", 2, 0, 0); push("t5_cnt", K_CNT, exp_cnt); tick();
        drain();

        // Asynchronous reset while a forward is active.
        alu_op(5'd5, 5'd1, 5'd2); tick();
        alu_op(5'd6, 5'd5, 5'd7); tick();
        nop(); exp3("t6_pre", 1, 0, 0); push("t6_pre_cnt", K_CNT, 4);
        @(negedge clk);
        #2;
        push("t6_async_sel1", K_SEL1, 0);
        push("t6_async_cnt", K_CNT, 0);
        rst_n = 1'b0;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Saturation: more load-use stalls than the counter can hold.
        for (int i = 0; i < 17; i++) begin
            load_op(5'd3, 5'd2); tick();
            alu_op(5'd4, 5'd3, 5'd1);
            push($sformatf("t7_stall_%0d", i), K_STALL, 1);
            push($sformatf("t7_cnt_%0d", i), K_CNT, exp_cnt);
            stall_seen(); tick();
            nop(); tick();
        end
        push("t7_sat", K_CNT, 15);
        tick();
        tick();
        done = 1'b1;
    end

    initial begin
        wait (done == 1'b1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
